// File: rtl/udp_tx_arb.sv
// udp_tx_arb: round-robin multi-channel front end for the UDP/IPv4 mac transmitter
module udp_tx_arb #(
  parameter int          CH_NUM       = 4,
  parameter int          LEN_W        = 16,
  parameter int          MAX_LEN      = 1472,
  parameter logic [15:0] IPV4_ID_INIT = 16'h0123,
  parameter int          GAP_CYC      = 48,
  parameter int          START_TO     = 1024
) (
  input  logic                    I_clk50m,
  input  logic                    I_rst,
  input  logic [CH_NUM-1:0]       I_ch_req,
  input  logic [CH_NUM*LEN_W-1:0] I_ch_len,
  input  logic [CH_NUM*LEN_W-1:0] I_ch_port,
  input  logic [CH_NUM*8-1:0]     I_ch_data,
  output logic [CH_NUM-1:0]       O_ch_grant,
  output logic [CH_NUM-1:0]       O_ch_load,
  output logic [CH_NUM-1:0]       O_ch_done,
  output logic [CH_NUM-1:0]       O_ch_err,
  output logic                    O_mac_en,
  output logic [LEN_W-1:0]        O_mac_len,
  output logic [LEN_W-1:0]        O_mac_port,
  output logic [15:0]             O_mac_ipv4_id,
  output logic [7:0]              O_mac_data,
  input  logic                    I_mac_busy,
  input  logic                    I_mac_load,
  output logic                    O_busy
);
  localparam int IW = CH_NUM > 1 ? $clog2(CH_NUM) : 1;
  localparam int CW = $clog2(START_TO + GAP_CYC + 1);
  typedef enum logic [2:0] {IDLE, ARB, START, WAIT_BUSY, SEND, GAP} state_t;
  state_t           state;
  logic [IW-1:0]    rr, idx, sel;
  logic             hit, busy_q;
  logic [CW-1:0]    cnt;
  logic [LEN_W-1:0] sel_len;
  int               j;
  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] v);
    return (v == IW'(CH_NUM - 1)) ? '0 : v + 1'b1;
  endfunction
  // first requesting channel at or after rr, scanning backwards so the nearest wins
  always_comb begin
    sel = '0;
    hit = 1'b0;
    j = 0;
    for (int i = CH_NUM - 1; i >= 0; i--) begin
      j = int'(rr) + i;
      j = (j >= CH_NUM) ? j - CH_NUM : j;
      if (I_ch_req[IW'(j)]) begin
        sel = IW'(j);
        hit = 1'b1;
      end
    end
    sel_len = I_ch_len[sel*LEN_W +: LEN_W];
  end
  assign O_ch_load  = {CH_NUM{I_mac_load}} & O_ch_grant;
  assign O_mac_data = (state == SEND) ? I_ch_data[idx*8 +: 8] : 8'h00;
  assign O_busy     = state != IDLE;
  // packet sequencing, latched mac fields, identification counter and status pulses
  always_ff @(posedge I_clk50m or negedge I_rst) begin
    if (!I_rst) begin
      state         <= IDLE;
      rr            <= '0;
      idx           <= '0;
      cnt           <= '0;
      busy_q        <= 1'b0;
      O_ch_grant    <= '0;
      O_ch_done     <= '0;
      O_ch_err      <= '0;
      O_mac_en      <= 1'b0;
      O_mac_len     <= '0;
      O_mac_port    <= '0;
      O_mac_ipv4_id <= IPV4_ID_INIT;
    end else begin
      busy_q    <= I_mac_busy;
      O_mac_en  <= 1'b0;
      O_ch_done <= '0;
      O_ch_err  <= '0;
      case (state)
        IDLE: if (|I_ch_req) state <= ARB;
        ARB: begin
          if (!hit) state <= IDLE;
          else if (sel_len == '0 || sel_len > LEN_W'(MAX_LEN)) begin
            O_ch_err <= CH_NUM'(1) << sel;
            rr       <= wrap_inc(sel);
            state    <= IDLE;
          end else begin
            idx        <= sel;
            O_mac_len  <= sel_len;
            O_mac_port <= I_ch_port[sel*LEN_W +: LEN_W];
            O_ch_grant <= CH_NUM'(1) << sel;
            O_mac_en   <= 1'b1;
            state      <= START;
          end
        end
        START: begin
          cnt   <= '0;
          state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (I_mac_busy) state <= SEND;
          else if (cnt == CW'(START_TO - 1)) begin
            O_ch_err   <= O_ch_grant;
            O_ch_grant <= '0;
            rr         <= wrap_inc(idx);
            cnt        <= '0;
            state      <= GAP;
          end else cnt <= cnt + 1'b1;
        end
        SEND: begin
          if (busy_q && !I_mac_busy) begin
            O_ch_done     <= O_ch_grant;
            O_ch_grant    <= '0;
            O_mac_ipv4_id <= O_mac_ipv4_id + 16'd1;
            rr            <= wrap_inc(idx);
            cnt           <= '0;
            state         <= GAP;
          end
        end
        GAP: begin
          if (cnt == CW'(GAP_CYC)) state <= IDLE;
          else cnt <= cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_udp_tx_arb.sv
// tb_udp_tx_arb: directed bench for udp_tx_arb with a simple mac handshake model
module tb_udp_tx_arb;
  localparam int CH = 4, LW = 16, GAP = 48, STO = 1024;
  logic clk = 1'b0;
  always #10 clk = ~clk;
  logic rst, busy, load;
  logic [CH-1:0] req, grant, ch_load, done, err;
  logic [CH*LW-1:0] len, port;
  logic [CH*8-1:0] data;
  logic en, obusy;
  logic [LW-1:0] mac_len, mac_port;
  logic [15:0] id;
  logic [7:0] mac_data;
  logic [CH-1:0] b_grant, b_load, b_done, b_err;
  logic b_en, b_busy;
  logic [LW-1:0] b_len, b_port;
  logic [15:0] b_id;
  logic [7:0] b_data;
  int errors = 0, checks = 0;
  int ld_cnt[CH];
  logic [7:0] first_byte;
  int n;
  logic [CH-1:0] err_acc, err_first;
  int en_cnt;
  udp_tx_arb #(.CH_NUM(CH), .LEN_W(LW), .GAP_CYC(GAP), .START_TO(STO)) dut (
    .I_clk50m(clk), .I_rst(rst), .I_ch_req(req), .I_ch_len(len), .I_ch_port(port),
    .I_ch_data(data), .O_ch_grant(grant), .O_ch_load(ch_load), .O_ch_done(done),
    .O_ch_err(err), .O_mac_en(en), .O_mac_len(mac_len), .O_mac_port(mac_port),
    .O_mac_ipv4_id(id), .O_mac_data(mac_data), .I_mac_busy(busy), .I_mac_load(load),
    .O_busy(obusy));
  udp_tx_arb #(.CH_NUM(CH), .LEN_W(LW), .IPV4_ID_INIT(16'hFFFF), .GAP_CYC(GAP), .START_TO(STO)) dut_wrap (
    .I_clk50m(clk), .I_rst(rst), .I_ch_req(req), .I_ch_len(len), .I_ch_port(port),
    .I_ch_data(data), .O_ch_grant(b_grant), .O_ch_load(b_load), .O_ch_done(b_done),
    .O_ch_err(b_err), .O_mac_en(b_en), .O_mac_len(b_len), .O_mac_port(b_port),
    .O_mac_ipv4_id(b_id), .O_mac_data(b_data), .I_mac_busy(busy), .I_mac_load(load),
    .O_busy(b_busy));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic set_ch(input int k, input int l, input int p);
    len[k*LW +: LW] = LW'(l);
    port[k*LW +: LW] = LW'(p);
  endtask
  task automatic wait_en(input int lim, output int c);
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!en && c < lim);
    if (!en) chk("en_timeout", 0, 1);
  endtask
  task automatic do_reset();
    req = '0;
    busy = 1'b0;
    load = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask
  task automatic mac_pkt(input int nb);
    for (int k = 0; k < CH; k++) ld_cnt[k] = 0;
    @(negedge clk);
    busy = 1'b1;
    @(negedge clk);
    for (int b = 0; b < nb; b++) begin
      load = 1'b1;
      #1;
      for (int k = 0; k < CH; k++) if (ch_load[k]) ld_cnt[k]++;
      if (b == 0) first_byte = mac_data;
      @(negedge clk);
    end
    load = 1'b0;
    busy = 1'b0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (|done) break;
    end
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    rst = 1'b1; req = '0; busy = 1'b0; load = 1'b0; len = '0; port = '0;
    data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    #5 rst = 1'b0;
    #1;
    chk("rst_busy", obusy, 0);
    chk("rst_grant", grant, 0);
    chk("rst_en", en, 0);
    chk("rst_load", ch_load, 0);
    chk("rst_id", id, 16'h0123);
    chk("rst_id_wrap", b_id, 16'hFFFF);
    @(negedge clk);
    rst = 1'b1;
    // single channel 1
    set_ch(1, 222, 11451);
    req = 4'b0010;
    @(negedge clk);
    chk("t1_arb_en", en, 0);
    chk("t1_arb_busy", obusy, 1);
    @(negedge clk);
    chk("t1_en", en, 1);
    chk("t1_grant", grant, 4'b0010);
    chk("t1_len", mac_len, 222);
    chk("t1_port", mac_port, 11451);
    chk("t1_id", id, 16'h0123);
    @(negedge clk);
    chk("t1_en_pulse", en, 0);
    mac_pkt(222);
    chk("t1_loads_ch1", ld_cnt[1], 222);
    chk("t1_loads_other", ld_cnt[0] + ld_cnt[2] + ld_cnt[3], 0);
    chk("t1_data", first_byte, 8'hA1);
    chk("t1_done", done, 4'b0010);
    chk("t1_grant_drop", grant, 0);
    chk("t1_id_inc", id, 16'h0124);
    chk("t1_id_wrap", b_id, 16'h0000);
    req = '0;
    do_reset();
    // four channels continuously requesting
    for (int k = 0; k < CH; k++) set_ch(k, 16, 1000 + k);
    req = 4'b1111;
    for (int p = 0; p < 5; p++) begin
      if (p == 0) begin
        wait_en(10, n);
        chk("t2_first_lat", n, 2);
      end else begin
        wait_en(200, n);
        chk("t2_gap", n, GAP + 3);
      end
      chk("t2_grant", grant, 4'b0001 << (p % CH));
      chk("t2_port", mac_port, 1000 + (p % CH));
      chk("t2_id", id, 16'h0123 + p);
      @(negedge clk);
      mac_pkt(16);
      chk("t2_done", done, 4'b0001 << (p % CH));
      chk("t2_loads", ld_cnt[p % CH], 16);
      chk("t2_data", first_byte, 8'hA0 + (p % CH));
      chk("t2_id_inc", id, 16'h0124 + p);
    end
    do_reset();
    // invalid lengths on channels 2 and 3
    set_ch(2, 0, 7);
    set_ch(3, 1500, 8);
    req = 4'b1100;
    err_acc = '0; err_first = '0; en_cnt = 0;
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      if (|err && err_first == '0) err_first = err;
      err_acc |= err;
      req &= ~err;
      if (en) en_cnt++;
    end
    chk("t3_err_first", err_first, 4'b0100);
    chk("t3_err_all", err_acc, 4'b1100);
    chk("t3_no_en", en_cnt, 0);
    chk("t3_id", id, 16'h0123);
    set_ch(1, 1473, 9);
    req = 4'b0010;
    err_acc = '0;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      err_acc |= err;
      req &= ~err;
    end
    chk("t3_err_1473", err_acc, 4'b0010);
    set_ch(0, 16, 100);
    set_ch(3, 16, 103);
    req = 4'b1001;
    wait_en(10, n);
    chk("t3_rr_grant", grant, 4'b1000);
    @(negedge clk);
    mac_pkt(16);
    chk("t3_done", done, 4'b1000);
    req = '0;
    // mac never goes busy, max-length packet
    set_ch(0, 1472, 55);
    req = 4'b0001;
    wait_en(200, n);
    chk("t4_grant", grant, 4'b0001);
    chk("t4_len", mac_len, 1472);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(|err) && n < 1200);
    chk("t4_to_cycles", n, STO + 1);
    chk("t4_err", err, 4'b0001);
    chk("t4_grant_drop", grant, 0);
    chk("t4_id", id, 16'h0124);
    req = '0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (obusy && n < 200);
    chk("t4_gap_idle", n, GAP + 1);
    // reset in the middle of SEND
    set_ch(1, 16, 200);
    req = 4'b0010;
    wait_en(10, n);
    chk("t6_grant", grant, 4'b0010);
    @(negedge clk);
    busy = 1'b1;
    @(negedge clk);
    load = 1'b1;
    #1;
    chk("t6_load_pre", ch_load, 4'b0010);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t6_busy", obusy, 0);
    chk("t6_grant0", grant, 0);
    chk("t6_load0", ch_load, 0);
    chk("t6_data0", mac_data, 0);
    chk("t6_len0", mac_len, 0);
    chk("t6_port0", mac_port, 0);
    chk("t6_id", id, 16'h0123);
    busy = 1'b0;
    load = 1'b0;
    req = '0;
    @(negedge clk);
    rst = 1'b1;
    set_ch(0, 16, 300);
    req = 4'b0011;
    wait_en(10, n);
    chk("t6_restart_lat", n, 2);
    chk("t6_restart_grant", grant, 4'b0001);
    do_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/udp_tx_arb.md
# udp_tx_arb

Multi-channel UDP transmit front end in the 50 MHz RMII domain, between N independent packet sources (camera, status, debug) and the single `mac` UDP/IPv4 transmitter. Each channel requests a packet with length and destination port; the block arbitrates round-robin, drives the mac start/length/identification inputs, steers the mac byte stream from the granted channel, and owns the IPv4 identification counter with fully synchronous increments. It replaces the fixed single-source wiring and the busy-edge-clocked ID counter in the current top level.

## Interface
- `CH_NUM`, 4: number of source channels, 1..8.
- `LEN_W`, 16: width of length and port fields.
- `MAX_LEN`, 1472: largest accepted UDP payload in bytes.
- `IPV4_ID_INIT`, 16'h0123: identification value after reset.
- `GAP_CYC`, 48: idle cycles enforced between packets (≥1).
- `START_TO`, 1024: cycles to wait for mac busy after start before aborting.

- `I_clk50m` in 1: RMII 50 MHz clock; all logic on rising edge.
- `I_rst` in 1: asynchronous, active-low reset.
- `I_ch_req` in CH_NUM: level request per channel; held until `O_ch_done` or `O_ch_err` for that channel.
- `I_ch_len` in CH_NUM*LEN_W: payload length per channel, channel k at [k*LEN_W +: LEN_W].
- `I_ch_port` in CH_NUM*LEN_W: UDP destination port per channel.
- `I_ch_data` in CH_NUM*8: payload byte per channel.
- `O_ch_grant` in→out CH_NUM: one-hot, granted channel, held from ARB to DONE.
- `O_ch_load` out CH_NUM: one-hot; granted channel must present next byte (mirrors mac load strobe).
- `O_ch_done` out CH_NUM: one-cycle pulse, packet fully sent.
- `O_ch_err` out CH_NUM: one-cycle pulse, request rejected or aborted.
- `O_mac_en` out 1: one-cycle start to mac.
- `O_mac_len` out LEN_W: latched payload length.
- `O_mac_port` out LEN_W: latched destination port.
- `O_mac_ipv4_id` out 16: identification for current packet.
- `O_mac_data` out 8: payload byte from granted channel.
- `I_mac_busy` in 1: mac busy.
- `I_mac_load` in 1: mac consuming a payload byte this cycle.
- `O_busy` out 1: high in every state except IDLE.

## Operation
- States: IDLE, ARB, START, WAIT_BUSY, SEND, GAP.
- IDLE: if any `I_ch_req` → ARB.
- ARB: select first requesting channel at or after `rr_ptr` (wrapping). If its length is 0 or > MAX_LEN: pulse `O_ch_err[k]`, `rr_ptr`←k+1 mod CH_NUM, → IDLE. Else latch index, length, port; assert grant; → START.
- START: `O_mac_en`=1 for exactly this cycle; → WAIT_BUSY, timeout counter cleared.
- WAIT_BUSY: on `I_mac_busy`=1 → SEND; if counter reaches START_TO-1 → pulse err, drop grant, `rr_ptr`←k+1, ID unchanged, → GAP.
- SEND: `O_mac_data` = `I_ch_data` byte of latched index (combinational mux); `O_ch_load` = `I_mac_load` & grant (combinational). On registered falling edge of `I_mac_busy`: pulse `O_ch_done[k]`, ID←ID+1 (wraps 16'hFFFF→0), `rr_ptr`←k+1 mod CH_NUM, drop grant, → GAP.
- GAP: count GAP_CYC cycles, then → IDLE. Requests ignored.
- Reset (any state, including mid-packet): state IDLE, all outputs 0, `O_mac_ipv4_id`=IPV4_ID_INIT, `rr_ptr`=0, counters 0. Partial packet is not resumed.
- Request dropped mid-SEND: ignored; packet completes with whatever bytes channel supplies.

## Timing
- Request seen in IDLE at cycle t: ARB at t+1, grant and latched fields valid t+2, `O_mac_en` high during t+2 only.
- `O_mac_len`, `O_mac_port`, `O_mac_ipv4_id` stable from t+2 until GAP entry.
- Busy fall sampled at cycle f: done pulse and ID increment in f+1; GAP entered f+1; earliest next `O_mac_en` f+1+GAP_CYC+3.
- Load/data path: zero-cycle combinational, same-cycle as `I_mac_load`.
- Simultaneous requests: strict round-robin; no channel granted twice while another valid requester waits.

## Test plan
- Single channel 1, len 222, port 11451: one `O_mac_en` pulse 2 cycles after req, grant=4'b0010, 222 load strobes routed to channel 1 only, done pulse, ID 0x0123→0x0124.
- All four channels request continuously, len 16: grant order 0,1,2,3,0; gap ≥ GAP_CYC between packets; ID increments by 1 per packet.
- Channel 2 len 0 and channel 3 len 1500: err pulses on 2 and 3, no `O_mac_en`, ID unchanged, rr advances.
- Mac busy never asserts: err pulse after START_TO cycles, state returns to IDLE after gap, ID unchanged.
- ID preset to 0xFFFF via IPV4_ID_INIT: after one packet ID=0x0000.
- Assert `I_rst` low mid-SEND: all outputs 0 immediately, ID=IPV4_ID_INIT, next request restarts from channel 0.
